// File: rtl/seq_divider.sv
// Iterative radix-2 divider, signed/unsigned per op. Latency accept->out_valid: WIDTH+2 cycles (2 for divide-by-zero).
// Accepts only in IDLE; the result is held in DONE until out_ready, which stalls any further accept.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r;
  logic             sgn_r;
  logic [WIDTH-1:0] dvd;   // dividend magnitude, shifts out MSB first and collects quotient bits
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             fits;

  assign a_neg   = sgn_r & a_r[WIDTH-1];
  assign b_neg   = sgn_r & b_r[WIDTH-1];
  // Partial remainder stays below |b|, so dropping rem[WIDTH] in the shift loses nothing.
  assign rem_sh  = (WIDTH+1)'({rem, dvd[WIDTH-1]});
  assign fits    = rem_sh >= {1'b0, dvs};
  assign rem_sub = rem_sh - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PREP;
      end
      // Divide-by-zero still passes through FIX so its result lands two cycles after accept.
      PREP: state_nxt = (b_r == '0) ? FIX : DIV;
      DIV:  if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sgn_r <= is_signed;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        PREP: begin
          dvd   <= a_neg ? -a_r : a_r;
          dvs   <= b_neg ? -b_r : b_r;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          if (b_r == '0) dbz <= 1'b1;
        end
        DIV: begin
          rem <= fits ? rem_sub : rem_sh;
          dvd <= {dvd[WIDTH-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (dbz) begin
            q <= '1;
            r <= a_r;
          end else begin
            // MIN / -1 needs no special case: negating MIN wraps back to MIN.
            q   <= neg_q ? -dvd : dvd;
            r   <= WIDTH'(neg_r ? -rem : rem);
            ovf <= sgn_r && (a_r == MIN_VAL) && (b_r == '1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a scoreboard of expected results.
module tb_seq_divider;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] q, r;
  logic         dbz, ovf;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .q(q), .r(r), .dbz(dbz), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic ed, input logic eo);
    return {eq, er, ed, eo};
  endfunction

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    res_t e;
    int   sa, sd;
    e = '0;
    if (bv == '0) begin
      e.q = '1; e.r = av; e.dbz = 1'b1;
    end else if (sv) begin
      sa = $signed(av);
      sd = $signed(bv);
      if (sa == -128 && sd == -1) begin
        e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1;
      end else begin
        e.q = 8'(sa / sd);
        e.r = 8'(sa % sd);
      end
    end else begin
      e.q = av / bv;
      e.r = av % bv;
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input res_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready before send", 32'(in_ready), 32'd1);
    a = av; b = bv; is_signed = sv; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag);
    res_t e;
    check({tag, " queue"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " q"},   32'(q),   32'(e.q));
    check({tag, " r"},   32'(r),   32'(e.r));
    check({tag, " dbz"}, 32'(dbz), 32'(e.dbz));
    check({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " retired"}, 32'(out_valid), 32'd0);
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int   lat;
    res_t tmp;
    wait_valid(lat);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (!out_valid) begin
      if (sb.size() > 0) tmp = sb.pop_front();
      return;
    end
    check({tag, " latency"}, lat, exp_lat);
    check_result(tag);
    retire(tag);
  endtask

  initial begin
    res_t         e, tmp;
    int           lat, seen;
    logic [W-1:0] av, bv;
    logic         sv;

    #12;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q",         32'(q),         32'd0);
    check("reset r",         32'(r),         32'd0);
    check("reset dbz",       32'(dbz),       32'd0);
    check("reset ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(8'd100, 8'd7,  1'b0, mk(8'd14,  8'd2,  1'b0, 1'b0)); collect("u100/7", 10);
    send(8'hF9,  8'h02, 1'b1, mk(8'hFD,  8'hFF, 1'b0, 1'b0)); collect("s-7/2", 10);
    send(8'h07,  8'hFE, 1'b1, mk(8'hFD,  8'h01, 1'b0, 1'b0)); collect("s7/-2", 10);
    send(8'd37,  8'd0,  1'b0, mk(8'hFF,  8'd37, 1'b1, 1'b0)); collect("u37/0", 2);
    send(8'd37,  8'd0,  1'b1, mk(8'hFF,  8'd37, 1'b1, 1'b0)); collect("s37/0", 2);
    send(8'h80,  8'hFF, 1'b1, mk(8'h80,  8'h00, 1'b0, 1'b1)); collect("s-128/-1", 10);
    send(8'h80,  8'hFF, 1'b0, mk(8'h00,  8'h80, 1'b0, 1'b0)); collect("u128/255", 10);
    send(8'h80,  8'h02, 1'b1, mk(8'hC0,  8'h00, 1'b0, 1'b0)); collect("s-128/2", 10);

    // Backpressure with a second op waiting on the input side.
    send(8'd200, 8'd9, 1'b0, mk(8'd22, 8'd2, 1'b0, 1'b0));
    wait_valid(lat);
    check("bp latency", lat, 10);
    e = sb[0];
    a = 8'd50; b = 8'd5; is_signed = 1'b0; in_valid = 1'b1;
    sb.push_back(mk(8'd10, 8'd0, 1'b0, 1'b0));
    repeat (5) begin
      check("bp hold q",   32'(q),   32'(e.q));
      check("bp hold r",   32'(r),   32'(e.r));
      check("bp hold dbz", 32'(dbz), 32'(e.dbz));
      check("bp hold ovf", 32'(ovf), 32'(e.ovf));
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    check_result("bp");
    retire("bp");
    @(negedge clk);
    check("bp2 in_ready after retire", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp2 accepted", 32'(in_ready), 32'd0);
    collect("bp2", 10);

    // Reset during DIV cycle 4, with a non-zero result still on q/r.
    send(8'd100, 8'd7, 1'b0, mk(8'd14, 8'd2, 1'b0, 1'b0)); collect("pre-rst", 10);
    send(8'd23, 8'd5, 1'b0, mk(8'd4, 8'd3, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready",  32'(in_ready),  32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst q",         32'(q),         32'd0);
    check("midrst r",         32'(r),         32'd0);
    check("midrst dbz",       32'(dbz),       32'd0);
    check("midrst ovf",       32'(ovf),       32'd0);
    if (sb.size() > 0) tmp = sb.pop_front();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("postrst no result", seen, 0);

    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      sv = 1'($urandom);
      case ($urandom_range(0, 9))
        0: bv = 8'h00;
        1: bv = 8'hFF;
        2: av = 8'h80;
        3: begin av = 8'h80; bv = 8'hFF; end
        default: ;
      endcase
      send(av, bv, sv, model(av, bv, sv));
      collect($sformatf("rand%0d", i), (bv == 8'h00) ? 2 : 10);
    end

    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
